// File: rtl/vx_elastic_pipe_pkg.sv
// Shared definitions for the elastic pipe slice.
//
// Holds the legal parameter ranges for the pipe and a helper that sizes the
// occupancy counter.
//
// Contents:
//   DATAW_MIN/MAX, DEPTH_MIN/MAX, NW_BITS_MIN/MAX : legal parameter ranges
//   count_width(depth)                            : bits needed to hold 0..depth
package vx_pipe_pkg;

    localparam int DATAW_MIN   = 1;
    localparam int DATAW_MAX   = 1024;
    localparam int DEPTH_MIN   = 1;
    localparam int DEPTH_MAX   = 8;
    localparam int NW_BITS_MIN = 1;
    localparam int NW_BITS_MAX = 6;

    // The counter has to represent every value from 0 to depth, so it needs
    // one more code point than the number of stages.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_elastic_pipe_if.sv
// Handshake bundle for vx_elastic_pipe.
//
// Groups the upstream beat, the flush request and the downstream beat.
//
// Signals:
//   valid_in/ready_in/data_in/wid_in       : upstream beat and its warp tag
//   flush/flush_wid                        : kill every beat tagged flush_wid
//   valid_out/ready_out/data_out/wid_out   : downstream beat and its warp tag
//
// Modports:
//   master : the environment (drives the upstream beat, flush and ready_out)
//   slave  : the pipe itself
interface vx_elastic_pipe_if #(
    parameter int DATAW   = 32,
    parameter int NW_BITS = 2
);

    logic               valid_in;
    logic               ready_in;
    logic [DATAW-1:0]   data_in;
    logic [NW_BITS-1:0] wid_in;
    logic               flush;
    logic [NW_BITS-1:0] flush_wid;
    logic               valid_out;
    logic               ready_out;
    logic [DATAW-1:0]   data_out;
    logic [NW_BITS-1:0] wid_out;

    modport master (
        output valid_in, data_in, wid_in, flush, flush_wid, ready_out,
        input  ready_in, valid_out, data_out, wid_out
    );

    modport slave (
        input  valid_in, data_in, wid_in, flush, flush_wid, ready_out,
        output ready_in, valid_out, data_out, wid_out
    );

endinterface

// File: rtl/vx_elastic_pipe_stage.sv
// One register stage of the elastic pipe.
//
// Holds a valid bit, a payload and a warp tag. The stage loads whenever it is
// empty or its occupant is leaving downstream; otherwise it holds. A flush
// kills a matching beat either as it is loaded or while it sits stalled here.
//
// Ports:
//   clk, reset             : clock and asynchronous active-high reset
//   valid_in/data_in/wid_in: beat offered by the previous stage (or upstream)
//   ready_next             : the next stage (or downstream) can take our beat
//   flush/flush_wid        : kill request and the warp tag it targets
//   valid_q/data_q/wid_q   : registered contents of this stage
module vx_pipe_stage #(
    parameter int DATAW   = 32,
    parameter int NW_BITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [DATAW-1:0]   data_in,
    input  logic [NW_BITS-1:0] wid_in,
    input  logic               ready_next,
    input  logic               flush,
    input  logic [NW_BITS-1:0] flush_wid,
    output logic               valid_q,
    output logic [DATAW-1:0]   data_q,
    output logic [NW_BITS-1:0] wid_q
);

    logic load;
    logic kill_in;
    logic kill_held;

    assign load      = !valid_q || ready_next;
    assign kill_in   = flush && (wid_in == flush_wid);
    assign kill_held = flush && (wid_q == flush_wid);

    // A beat that is moving on is not killed here: it is killed when it lands
    // in the next stage, or it retires at the output because the downstream
    // handshake takes priority over the flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= valid_in && !kill_in;
        end else begin
            valid_q <= valid_q && !kill_held;
        end
    end

    // Payload is don't-care while the stage is invalid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load && valid_in) begin
            data_q <= data_in;
            wid_q  <= wid_in;
        end
    end

endmodule

// File: rtl/vx_elastic_pipe.sv
// Elastic, flushable pipeline of DEPTH register stages.
//
// Beats carry a payload and a warp id. Ready propagates backwards through the
// stages combinationally so bubbles collapse, and a flush removes every beat
// tagged with flush_wid.
//
// Parameters: DATAW (payload bits), DEPTH (stages), NW_BITS (warp id bits).
//
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   bus         : vx_elastic_pipe_if slave (handshakes, payload, flush)
//   count       : number of stages currently holding a beat
//   busy        : count != 0
//   perf_stalls : only with VX_ELASTIC_PIPE_PERF_EN defined; saturating count
//                 of cycles where the output is valid but not accepted
module vx_elastic_pipe
    import vx_pipe_pkg::*;
#(
    parameter int DATAW   = 32,
    parameter int DEPTH   = 3,
    parameter int NW_BITS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    vx_elastic_pipe_if.slave               bus,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic                           busy
`ifdef VX_ELASTIC_PIPE_PERF_EN
    ,
    output logic [31:0]                    perf_stalls
`endif
);

    localparam int CNT_W = count_width(DEPTH);

    if (DATAW < DATAW_MIN || DATAW > DATAW_MAX ||
        DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        NW_BITS < NW_BITS_MIN || NW_BITS > NW_BITS_MAX) begin : g_bad_params
        $error("vx_elastic_pipe: parameter out of range");
    end

    logic [DEPTH-1:0]   valid_q;
    logic [DATAW-1:0]   data_q [DEPTH];
    logic [NW_BITS-1:0] wid_q  [DEPTH];
    logic [DEPTH:0]     stage_ready;

    // Walk from the output back to the input: a stage can accept when it is
    // empty or when everything in front of it can move.
    always_comb begin
        stage_ready[DEPTH] = bus.ready_out;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            stage_ready[i] = !valid_q[i] || stage_ready[i+1];
        end
    end

    // Stage 0 is fed from the interface, every later stage from its neighbour.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic               stage_valid_in;
        logic [DATAW-1:0]   stage_data_in;
        logic [NW_BITS-1:0] stage_wid_in;

        if (i == 0) begin : g_head
            assign stage_valid_in = bus.valid_in;
            assign stage_data_in  = bus.data_in;
            assign stage_wid_in   = bus.wid_in;
        end else begin : g_body
            assign stage_valid_in = valid_q[i-1];
            assign stage_data_in  = data_q[i-1];
            assign stage_wid_in   = wid_q[i-1];
        end

        vx_pipe_stage #(
            .DATAW   (DATAW),
            .NW_BITS (NW_BITS)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .valid_in   (stage_valid_in),
            .data_in    (stage_data_in),
            .wid_in     (stage_wid_in),
            .ready_next (stage_ready[i+1]),
            .flush      (bus.flush),
            .flush_wid  (bus.flush_wid),
            .valid_q    (valid_q[i]),
            .data_q     (data_q[i]),
            .wid_q      (wid_q[i])
        );
    end

    assign bus.ready_in  = stage_ready[0];
    assign bus.valid_out = valid_q[DEPTH-1];
    assign bus.data_out  = data_q[DEPTH-1];
    assign bus.wid_out   = wid_q[DEPTH-1];

    // Occupancy follows the valid bits directly, so flush kills show up in the
    // same cycle the bits clear.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    assign busy = |valid_q;

`ifdef VX_ELASTIC_PIPE_PERF_EN
    // Count output stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (bus.valid_out && !bus.ready_out && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
